// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and
// multi-cycle (FPU / crypto) dispatch, with a busy watchdog and a stall counter.
module pipe_stall_ctrl #(
    parameter int unsigned REG_W   = 3,
    parameter int unsigned TMO_CYC = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic             PCSrcE,
    input  logic             McReqE,
    input  logic             McSelE,
    input  logic             fpu_done,
    input  logic             cry_done,
    output logic             fpu_start,
    output logic             cry_start,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TMR_W = $clog2(TMO_CYC);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t             state;
    state_t             stateNext;
    logic [TMR_W-1:0]   timer;
    logic               selLatched;
    logic               dispatch;
    logic               loadUse;
    logic               mcDone;
    logic               timeout;

    assign loadUse = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mcDone  = selLatched ? cry_done : fpu_done;
    assign timeout = (timer == TMR_W'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Mealy decode; every control is held low while reset is asserted
    always_comb begin
        stateNext = state;
        dispatch  = 1'b0;
        fpu_start = 1'b0;
        cry_start = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        case (state)
            IDLE: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (McReqE) begin
                    dispatch  = 1'b1;
                    fpu_start = !McSelE;
                    cry_start = McSelE;
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    FlushM    = 1'b1;
                    stateNext = BUSY;
                end else if (loadUse) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            BUSY: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
                if (mcDone)       stateNext = DONE;
                else if (timeout) stateNext = ERR;
            end
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (!rst) begin
            dispatch  = 1'b0;
            fpu_start = 1'b0;
            cry_start = 1'b0;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
        end
    end

    // Watchdog timer, unit select, sticky error and saturating stall counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer      <= '0;
            selLatched <= 1'b0;
            mc_err     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (dispatch) begin
                timer      <= '0;
                selLatched <= McSelE;
            end else if (state == BUSY) begin
                timer <= timer + TMR_W'(1);
            end
            if ((state == BUSY) && !mcDone && timeout) mc_err <= 1'b1;
            if (StallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expected control vectors are queued per
// driven cycle and compared against the DUT on the falling edge.
module tb_pipe_stall_ctrl;

    localparam int unsigned REG_W   = 3;
    localparam int unsigned TMO_CYC = 64;
    localparam int unsigned CNT_W   = 8;

    // {fpu_start, cry_start, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] LDUSE  = 8'b0011_0010;
    localparam logic [7:0] BRANCH = 8'b0000_0110;
    localparam logic [7:0] DISPF  = 8'b1011_1001;
    localparam logic [7:0] DISPC  = 8'b0111_1001;
    localparam logic [7:0] BUSYV  = 8'b0011_1001;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             MemReadE = 1'b0;
    logic [REG_W-1:0] RdE = '0;
    logic [REG_W-1:0] Rs1D = '0;
    logic [REG_W-1:0] Rs2D = '0;
    logic             PCSrcE = 1'b0;
    logic             McReqE = 1'b0;
    logic             McSelE = 1'b0;
    logic             fpu_done = 1'b0;
    logic             cry_done = 1'b0;
    logic             fpu_start, cry_start, StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM, mc_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       ctlObs;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    pipe_stall_ctrl #(.REG_W(REG_W), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .MemReadE(MemReadE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .PCSrcE(PCSrcE), .McReqE(McReqE), .McSelE(McSelE),
        .fpu_done(fpu_done), .cry_done(cry_done),
        .fpu_start(fpu_start), .cry_start(cry_start),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    assign ctlObs = {fpu_start, cry_start, StallF, StallD, StallE, FlushD, FlushE, FlushM};

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected control vector for the current cycle, compare mid-cycle, advance
    task automatic step(input string tag, input logic [7:0] expCtl);
        logic [7:0] e;
        expQ.push_back(expCtl);
        @(negedge clk);
        e = expQ.pop_front();
        checkVal(tag, 32'(ctlObs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_ctl", 32'(ctlObs), 32'(NONE));
        checkVal("rst_cnt", 32'(stall_cnt), 32'd0);
        checkVal("rst_err", 32'(mc_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // load-use on Rs2D, then Rs1D, then the x0 and no-load cases
        MemReadE = 1'b1; RdE = 3'd3; Rs1D = 3'd1; Rs2D = 3'd3;
        step("t2_lu_rs2", LDUSE);
        MemReadE = 1'b0;
        step("t2_clear", NONE);
        MemReadE = 1'b1; RdE = 3'd5; Rs1D = 3'd5; Rs2D = 3'd2;
        step("t2_lu_rs1", LDUSE);
        RdE = 3'd0; Rs1D = 3'd0; Rs2D = 3'd0;
        step("t2_rd0", NONE);
        MemReadE = 1'b0; RdE = 3'd4; Rs1D = 3'd4;
        step("t2_noload", NONE);
        checkVal("t2_cnt", 32'(stall_cnt), 32'd2);

        // branch beats load-use and dispatch
        MemReadE = 1'b1; RdE = 3'd3; Rs2D = 3'd3; McReqE = 1'b1; PCSrcE = 1'b1;
        step("t3_branch", BRANCH);
        MemReadE = 1'b0; McReqE = 1'b0; PCSrcE = 1'b0;
        step("t3_after", NONE);
        checkVal("t3_cnt", 32'(stall_cnt), 32'd2);

        // FPU op with done four cycles after start
        McReqE = 1'b1; McSelE = 1'b0;
        step("t4_disp", DISPF);
        McReqE = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            fpu_done = (k == 4);
            step("t4_busy", BUSYV);
        end
        fpu_done = 1'b0; PCSrcE = 1'b1;
        step("t4_done", NONE);
        step("t4_br_next", BRANCH);
        PCSrcE = 1'b0;
        checkVal("t4_cnt", 32'(stall_cnt), 32'd7);

        // done pulses in IDLE are ignored
        cry_done = 1'b1; fpu_done = 1'b1;
        step("idle_done", NONE);
        cry_done = 1'b0; fpu_done = 1'b0;
        step("idle_after", NONE);

        // crypto op: stray fpu_done ignored, done coincides with last timer value
        McReqE = 1'b1; McSelE = 1'b1;
        step("t6_disp", DISPC);
        McReqE = 1'b0;
        for (int k = 0; k < 64; k++) begin
            fpu_done = (k == 2);
            cry_done = (k == 63);
            step("t6_busy", BUSYV);
        end
        fpu_done = 1'b0; cry_done = 1'b0;
        step("t6_done", NONE);
        checkVal("t6_err", 32'(mc_err), 32'd0);
        checkVal("t6_cnt", 32'(stall_cnt), 32'd72);

        // crypto op never completes: 64 busy cycles, then ERR
        McReqE = 1'b1; McSelE = 1'b1;
        step("t5_disp", DISPC);
        McReqE = 1'b0;
        for (int k = 0; k < 64; k++) step("t5_busy", BUSYV);
        step("t5_errcyc", NONE);
        checkVal("t5_err", 32'(mc_err), 32'd1);
        step("t5_idle", NONE);
        checkVal("t5_err_sticky", 32'(mc_err), 32'd1);
        checkVal("t5_cnt", 32'(stall_cnt), 32'd137);

        // fastest FPU op after an error: done on the first busy cycle
        McReqE = 1'b1; McSelE = 1'b0;
        step("fast_disp", DISPF);
        McReqE = 1'b0; fpu_done = 1'b1;
        step("fast_busy", BUSYV);
        fpu_done = 1'b0;
        step("fast_done", NONE);
        checkVal("fast_err", 32'(mc_err), 32'd1);
        checkVal("fast_cnt", 32'(stall_cnt), 32'd139);

        // held load-use drives the counter into saturation
        MemReadE = 1'b1; RdE = 3'd2; Rs1D = 3'd2; Rs2D = 3'd0;
        for (int k = 0; k < 130; k++) step("sat_lu", LDUSE);
        MemReadE = 1'b0;
        step("sat_clear", NONE);
        checkVal("sat_cnt", 32'(stall_cnt), 32'd255);

        // reset in the middle of a busy period
        McReqE = 1'b1; McSelE = 1'b0;
        step("t1_disp", DISPF);
        McReqE = 1'b0;
        step("t1_busy1", BUSYV);
        step("t1_busy2", BUSYV);
        rst = 1'b0;
        #1;
        checkVal("t1_ctl", 32'(ctlObs), 32'(NONE));
        checkVal("t1_cnt", 32'(stall_cnt), 32'd0);
        checkVal("t1_err", 32'(mc_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step("t1_idle", NONE);
        checkVal("t1_cnt_after", 32'(stall_cnt), 32'd0);
        MemReadE = 1'b1; RdE = 3'd6; Rs2D = 3'd6;
        step("t1_lu", LDUSE);
        MemReadE = 1'b0;
        checkVal("t1_cnt_lu", 32'(stall_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
